// File: rtl/xadc_drp_sampler.sv
// xadc_drp_sampler
// Periodically reads one XADC status register over DRP. It publishes each
// raw 12-bit conversion code and a block average of 2^AVG_LOG2 codes, and
// abandons reads whose drdy does not arrive within TIMEOUT cycles.
//
// Ports
//   clk          : single clock, also used as the DRP dclk
//   rst_n        : asynchronous active-low reset
//   daddr        : DRP address, constant CH_ADDR
//   den          : DRP read enable, one-cycle pulse per read
//   drdy         : DRP data ready
//   do_in        : DRP read data, conversion code in [15:4]
//   sample       : last raw conversion code
//   sample_valid : one-cycle strobe when sample updates
//   avg          : last block average
//   avg_valid    : one-cycle strobe when avg updates
//   timeout_err  : one-cycle strobe when a read is abandoned
//   err_cnt      : saturating timeout count
module xadc_drp_sampler #(
  parameter int         SAMPLE_DIV = 100000,
  parameter int         AVG_LOG2   = 4,
  parameter logic [6:0] CH_ADDR    = 7'h11,
  parameter int         TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [6:0]  daddr,
  output logic        den,
  input  logic        drdy,
  input  logic [15:0] do_in,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic [11:0] avg,
  output logic        avg_valid,
  output logic        timeout_err,
  output logic [7:0]  err_cnt
);

  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT);
  // With AVG_LOG2=0 this is 0, so every sample closes its own block.
  localparam logic [CW-1:0] SMP_LAST  = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [TW-1:0]   r_tick_cnt;
  logic [WW-1:0]   r_wait_cnt;
  logic [AW-1:0]   r_acc;
  logic [CW-1:0]   r_smp_cnt;
  logic            r_den;
  logic [11:0]     r_sample;
  logic            r_sample_valid;
  logic [11:0]     r_avg;
  logic            r_avg_valid;
  logic            r_timeout_err;
  logic [7:0]      r_err_cnt;

  logic            w_tick;
  logic            w_accept;
  logic            w_timeout;
  logic [11:0]     w_code;
  logic [AW-1:0]   w_sum;
  logic [11:0]     w_avg_next;
  logic            w_block_last;
  logic            w_unused_ok;

  assign daddr        = CH_ADDR;
  assign den          = r_den;
  assign sample       = r_sample;
  assign sample_valid = r_sample_valid;
  assign avg          = r_avg;
  assign avg_valid    = r_avg_valid;
  assign timeout_err  = r_timeout_err;
  assign err_cnt      = r_err_cnt;

  assign w_tick       = (r_tick_cnt == TICK_LAST);
  assign w_code       = do_in[15:4];
  assign w_unused_ok  = ^do_in[3:0];
  // The accumulator is wide enough for a full block, so the sum never wraps.
  assign w_sum        = r_acc + AW'(w_code);
  assign w_avg_next   = w_sum[AVG_LOG2 +: 12];
  assign w_block_last = (r_smp_cnt == SMP_LAST);

  // Free-running sample-rate counter; wraps on its own compare so that an
  // externally disturbed tick cannot shift the schedule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= {TW{1'b0}};
    end else if (r_tick_cnt == TICK_LAST) begin
      r_tick_cnt <= {TW{1'b0}};
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; drdy wins over timeout on the last wait cycle.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick) begin
          w_state_next = ST_REQ;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (drdy) begin
          w_accept     = 1'b1;
          w_state_next = ST_IDLE;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_WAIT;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Wait-cycle counter: reads 1 on the first WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= {WW{1'b0}};
    end else if (r_state == ST_REQ) begin
      r_wait_cnt <= WW'(1);
    end else if ((r_state == ST_WAIT) && (r_wait_cnt != WAIT_LAST)) begin
      r_wait_cnt <= r_wait_cnt + WW'(1);
    end else begin
      r_wait_cnt <= {WW{1'b0}};
    end
  end

  // Registered den: high exactly while the FSM sits in REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_den <= 1'b0;
    end else begin
      r_den <= (w_state_next == ST_REQ);
    end
  end

  // Sample capture and block averaging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample       <= 12'h000;
      r_sample_valid <= 1'b0;
      r_avg          <= 12'h000;
      r_avg_valid    <= 1'b0;
      r_acc          <= {AW{1'b0}};
      r_smp_cnt      <= {CW{1'b0}};
    end else begin
      r_sample_valid <= 1'b0;
      r_avg_valid    <= 1'b0;
      if (w_accept) begin
        r_sample       <= w_code;
        r_sample_valid <= 1'b1;
        if (w_block_last) begin
          r_avg       <= w_avg_next;
          r_avg_valid <= 1'b1;
          r_acc       <= {AW{1'b0}};
          r_smp_cnt   <= {CW{1'b0}};
        end else begin
          r_acc     <= w_sum;
          r_smp_cnt <= r_smp_cnt + CW'(1);
        end
      end else begin
        r_acc     <= r_acc;
        r_smp_cnt <= r_smp_cnt;
      end
    end
  end

  // Timeout strobe and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout_err <= 1'b0;
      r_err_cnt     <= 8'h00;
    end else begin
      r_timeout_err <= w_timeout;
      if (w_timeout && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'h01;
      end else begin
        r_err_cnt <= r_err_cnt;
      end
    end
  end

endmodule
